led_blink_bank: RTL and testbench

Parametrised bank of independent LED drivers running on CLOCK_50, the successor to the single-LED 1 Hz blinker. Each channel has its own programmable half-period and a mode (off, on, blink, one-shot pulse), set through a simple single-cycle write port. A global phase-sync input realigns all blinking channels. The block sits between board-level control logic and the LEDG pins.

---
 rtl/led_blink_bank.sv | 111 +++++++++++
 tb/tb_led_blink_bank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_bank.sv
// Bank of independent LED drivers: each channel is off, on, blinking with a
// programmable half-period, or a one-shot pulse. Configured via a one-cycle write port.
module led_blink_bank #(
    parameter int          CHANNELS   = 8,
    parameter int          CNT_W      = 26,
    parameter int unsigned DIV_RESET  = 50000000,
    parameter logic [1:0]  MODE_RESET = 2'b10,
    localparam int         CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLOCK_50,
    input  logic                KEY0,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic                sync_all,
    output logic [CHANNELS-1:0] LEDG
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);

    mode_t               r_mode [CHANNELS];
    logic [CNT_W-1:0]    r_div  [CHANNELS];
    logic [CNT_W-1:0]    r_cnt  [CHANNELS];
    logic [CHANNELS-1:0] r_led;
    logic [CHANNELS-1:0] r_done;

    logic [CNT_W-1:0]    w_last [CHANNELS];
    logic [CHANNELS-1:0] w_hit;

    // Per-channel terminal count (D-1, with a zero divisor acting as 1) and write decode
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // Matching a real index implies the address is in range
            w_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
            if (r_div[i] == '0) begin
                w_last[i] = '0;
            end else begin
                w_last[i] = r_div[i] - CNT_W'(1);
            end
        end
    end

    // Channel state: reset, then write, then sync, then normal mode behaviour
    always_ff @(posedge CLOCK_50) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (KEY0) begin
                r_mode[i] <= mode_t'(MODE_RESET);
                r_div[i]  <= DIV_INIT;
                r_cnt[i]  <= '0;
                r_led[i]  <= 1'b0;
                r_done[i] <= 1'b0;
            end else if (w_hit[i]) begin
                r_mode[i] <= mode_t'(cfg_mode);
                r_div[i]  <= cfg_div;
                r_cnt[i]  <= '0;
                r_led[i]  <= cfg_mode[0];
                r_done[i] <= 1'b0;
            end else if (sync_all && (r_mode[i] == MODE_BLINK)) begin
                r_cnt[i]  <= '0;
                r_led[i]  <= 1'b0;
            end else begin
                case (r_mode[i])
                    MODE_OFF: begin
                        r_cnt[i] <= '0;
                        r_led[i] <= 1'b0;
                    end
                    MODE_ON: begin
                        r_cnt[i] <= '0;
                        r_led[i] <= 1'b1;
                    end
                    MODE_BLINK: begin
                        if (r_cnt[i] == w_last[i]) begin
                            r_cnt[i] <= '0;
                            r_led[i] <= ~r_led[i];
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        // Once done, the counter freezes and the LED stays low until rewritten
                        if (!r_done[i]) begin
                            if (r_cnt[i] == w_last[i]) begin
                                r_led[i]  <= 1'b0;
                                r_done[i] <= 1'b1;
                            end else begin
                                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                            end
                        end else begin
                            r_cnt[i] <= r_cnt[i];
                        end
                    end
                    default: begin
                        r_cnt[i] <= '0;
                        r_led[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign LEDG = r_led;

endmodule

// File: tb/tb_led_blink_bank.sv
// Randomised and directed bench for led_blink_bank; LED levels are predicted from
// elapsed time since each channel's last (re)start.
module tb_led_blink_bank;

    localparam int         CH    = 6;
    localparam int         CW    = 8;
    localparam int         DRST  = 4;
    localparam logic [1:0] MRST  = 2'b10;
    localparam int         CHW   = 3;

    logic            clk = 1'b0;
    logic            key0 = 1'b1;
    logic            cfg_we = 1'b0;
    logic [CHW-1:0]  cfg_ch = '0;
    logic [1:0]      cfg_mode = 2'b00;
    logic [CW-1:0]   cfg_div = '0;
    logic            sync_all = 1'b0;
    logic [CH-1:0]   ledg;

    int n_checks = 0;
    int n_errors = 0;

    led_blink_bank #(
        .CHANNELS  (CH),
        .CNT_W     (CW),
        .DIV_RESET (DRST),
        .MODE_RESET(MRST)
    ) dut (
        .CLOCK_50(clk),
        .KEY0    (key0),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_div (cfg_div),
        .sync_all(sync_all),
        .LEDG    (ledg)
    );

    always #5 clk = ~clk;

    // Reference model: each channel remembers its mode, divisor and the edge it (re)started on
    int            t = 0;
    int            m_mode  [CH];
    int            m_div   [CH];
    int            m_start [CH];
    bit            m_armed [CH];
    bit            m_rst = 1'b0;
    logic [CH-1:0] exp_ledg = '0;
    bit            model_valid = 1'b0;

    function automatic logic exp_led(int c);
        int d;
        int k;
        d = (m_div[c] == 0) ? 1 : m_div[c];
        k = t - m_start[c];
        if (m_rst) return 1'b0;
        case (m_mode[c])
            0: return 1'b0;
            1: return 1'b1;
            2: return logic'((k / d) % 2);
            3: return m_armed[c] && (k < d);
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        t = t + 1;
        if (key0) begin
            m_rst = 1'b1;
            for (int c = 0; c < CH; c++) begin
                m_mode[c]  = int'(MRST);
                m_div[c]   = DRST;
                m_start[c] = t;
                m_armed[c] = 1'b0;
            end
        end else begin
            m_rst = 1'b0;
            for (int c = 0; c < CH; c++) begin
                if (cfg_we && (int'(cfg_ch) == c)) begin
                    m_mode[c]  = int'(cfg_mode);
                    m_div[c]   = int'(cfg_div);
                    m_start[c] = t;
                    m_armed[c] = 1'b1;
                end else if (sync_all && (m_mode[c] == 2)) begin
                    m_start[c] = t;
                end
            end
        end
        for (int c = 0; c < CH; c++) exp_ledg[c] = exp_led(c);
        model_valid = 1'b1;
    end

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    // Every cycle: DUT output against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (model_valid) check("model", int'(ledg), int'(exp_ledg));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(int ch, int mode, int div);
        cfg_we   = 1'b1;
        cfg_ch   = CHW'(ch);
        cfg_mode = 2'(mode);
        cfg_div  = CW'(div);
        step();
        cfg_we   = 1'b0;
    endtask

    initial begin
        // Reset held for three edges, then blink from reset with D=4
        repeat (3) step();
        check("reset_hold", int'(ledg), 0);
        key0 = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            step();
            check("blink_after_reset", int'(ledg), ((n / 4) % 2 == 1) ? 63 : 0);
        end

        // One-shot on ch2, div 5, written at edge 10
        write(2, 3, 5);
        check("oneshot_start", int'(ledg[2]), 1);
        for (int n = 11; n <= 65; n++) begin
            step();
            check("oneshot", int'(ledg[2]), (n <= 14) ? 1 : 0);
        end

        // div 0 blink toggles every cycle
        write(1, 2, 0);
        check("div0_first", int'(ledg[1]), 0);
        for (int j = 1; j <= 8; j++) begin
            step();
            check("div0_toggle", int'(ledg[1]), j % 2);
        end

        // Static on then off
        write(3, 1, 7);
        check("on_write", int'(ledg[3]), 1);
        repeat (4) begin
            step();
            check("on_hold", int'(ledg[3]), 1);
        end
        write(3, 0, 7);
        check("off_write", int'(ledg[3]), 0);
        repeat (4) begin
            step();
            check("off_hold", int'(ledg[3]), 0);
        end

        // Fresh reset, sync at edge 6 with a same-cycle write to ch0
        key0 = 1'b1;
        step();
        check("reset_again", int'(ledg), 0);
        key0 = 1'b0;
        repeat (5) step();
        sync_all = 1'b1;
        write(0, 1, 4);
        sync_all = 1'b0;
        check("sync_edge6", int'(ledg), 6'b000001);
        for (int n = 7; n <= 9; n++) begin
            step();
            check("sync_low", int'(ledg), 6'b000001);
        end
        step();
        check("sync_toggle_e10", int'(ledg), 6'b111111);

        // Out-of-range addresses are ignored
        write(6, 0, 1);
        check("oor_ch6", int'(ledg), 6'b111111);
        write(7, 0, 1);
        check("oor_ch7", int'(ledg), 6'b111111);
        step();
        check("oor_e13", int'(ledg), 6'b111111);
        step();
        check("oor_e14", int'(ledg), 6'b000001);

        // Reset aborts a running one-shot
        write(4, 3, 10);
        check("oneshot_ch4", int'(ledg), 6'b010001);
        key0 = 1'b1;
        step();
        check("reset_abort", int'(ledg), 0);
        key0 = 1'b0;

        // Random traffic, checked every cycle against the model
        for (int n = 0; n < 10000; n++) begin
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_ch   = CHW'($urandom_range(0, 7));
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_div  = CW'($urandom_range(0, 9));
            sync_all = ($urandom_range(0, 15) == 0);
            key0     = ($urandom_range(0, 499) == 0);
            step();
        end
        cfg_we   = 1'b0;
        sync_all = 1'b0;
        key0     = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
